// File: rtl/encoder_rr_sched_if.sv
// Request/response bundle between the requester ports, the response consumer and the
// round-robin encoder scheduler.
interface encoder_rr_sched_if #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*IN_W-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [OUT_W-1:0]     rsp_data;
    logic [ID_W-1:0]      rsp_id;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/encoder_rr_sched.sv
// Round-robin arbiter that time-shares one combinational encoder: drive the winner's
// word for a full cycle, capture the result, return it with the requester index.
module encoder_rr_sched #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    encoder_rr_sched_if.slave    bus,
    output logic [IN_W-1:0]      enc_in,
    input  logic [OUT_W-1:0]     enc_out,
    output logic                 busy
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id_p0;
    logic [ID_W-1:0]  ptr_next;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic             rsp_valid_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic [ID_W-1:0]  rsp_id_q;

    // Scan ptr, ptr+1, ... with an explicit wrap so the search never leaves 0..NREQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = int'(ptr) + k;
            if (i >= NREQ) i = i - NREQ;
            if (!grant_found && bus.req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
                grant_oh[i] = 1'b1;
            end
        end
    end

    assign ptr_next = (id_p0 == ID_W'(NREQ - 1)) ? '0 : id_p0 + 1'b1;

    // Accept is only offered from IDLE, and never while reset is held.
    assign bus.req_ready = (rst_n && state == IDLE) ? grant_oh : '0;
    assign busy          = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            id_p0       <= '0;
            enc_in      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        enc_in <= bus.req_data[int'(grant_idx)*IN_W +: IN_W];
                        id_p0  <= grant_idx;
                        state  <= EVAL;
                    end
                end
                // enc_in has been stable for the whole cycle; enc_out is settled here.
                EVAL: begin
                    rsp_data_q  <= enc_out;
                    rsp_id_q    <= id_p0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr         <= ptr_next;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
